// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus-interface unit: transfer FSM states and level-width helper.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    BusIdle  = 2'd0,
    BusWrite = 2'd1,
    BusRead  = 2'd2
  } bus_state_t;

  // Occupancy counters need one extra bit so "full" is representable.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_bus_interface_if.sv
// Core-side request/response and memory-side handshake signals of the bus-interface unit.
interface cpu_bus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              core_valid;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ready;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // master = core plus memory environment, slave = the bus-interface unit
  modport master (
    output core_valid, core_we, core_addr, core_wdata, mem_ack, mem_rdata,
    input  core_ready, core_rdata, core_rvalid, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  core_valid, core_we, core_addr, core_wdata, mem_ack, mem_rdata,
    output core_ready, core_rdata, core_rvalid, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the posted-write buffer; DEPTH must be a power of two.
module sync_fifo
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [lvl_width(DEPTH)-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == LVL_W'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cpu_bus_interface.sv
// Bus-interface unit: posted-write buffer, valid/ack memory handshake, read-after-write ordering.
// Optional watchdog abort of hung transfers is compiled in with BUS_TIMEOUT_EN.
module cpu_bus_interface
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int WBUF_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk_in,
  input  logic                             reset,
  cpu_bus_if.slave                         bus,
  output logic [lvl_width(WBUF_DEPTH)-1:0] wbuf_level,
  output logic                             bus_error
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wentry_t;

  bus_state_t        state, state_nxt;
  wentry_t           push_ent, head;
  logic              full, empty, pop;
  logic              wr_acc, rd_acc, abort;

  logic              mem_req_q, mem_req_nxt;
  logic              mem_we_q, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic              rvalid_q, rvalid_nxt;

  assign bus.core_ready  = bus.core_we ? !full : (empty && state == BusIdle);
  assign wr_acc          = bus.core_valid && bus.core_we && !full;
  assign rd_acc          = bus.core_valid && !bus.core_we && empty && state == BusIdle;
  assign push_ent        = '{addr: bus.core_addr, data: bus.core_wdata};

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.core_rdata  = rdata_q;
  assign bus.core_rvalid = rvalid_q;

  sync_fifo #(
    .WIDTH ($bits(wentry_t)),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (wr_acc),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (wbuf_level)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES);
  logic [WCNT_W-1:0] wait_cnt;
  logic              bus_error_q;

  // wait_cnt is 0 in the first request cycle, so abort lands in request cycle TIMEOUT_CYCLES.
  assign abort     = (state != BusIdle) && !bus.mem_ack &&
                     (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error = bus_error_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      wait_cnt    <= (state == BusIdle) ? '0 : wait_cnt + 1'b1;
      bus_error_q <= abort;
    end
  end
`else
  assign abort     = 1'b0;
  assign bus_error = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req_q;
    mem_we_nxt    = mem_we_q;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    rdata_nxt     = rdata_q;
    rvalid_nxt    = 1'b0;
    pop           = 1'b0;
    case (state)
      BusIdle: begin
        // A write landing in an empty buffer is issued straight from the core bus;
        // it is still pushed and becomes the head that the ack pops.
        if (!empty || wr_acc) begin
          state_nxt     = BusWrite;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b1;
          mem_addr_nxt  = empty ? push_ent.addr : head.addr;
          mem_wdata_nxt = empty ? push_ent.data : head.data;
        end else if (rd_acc) begin
          state_nxt    = BusRead;
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = bus.core_addr;
        end
      end
      BusWrite: begin
        if (bus.mem_ack || abort) begin
          state_nxt   = BusIdle;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          pop         = 1'b1;
        end
      end
      BusRead: begin
        if (bus.mem_ack || abort) begin
          state_nxt   = BusIdle;
          mem_req_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          rdata_nxt   = bus.mem_ack ? bus.mem_rdata : '1;
        end
      end
      default: begin
        state_nxt   = BusIdle;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= BusIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_req_q   <= mem_req_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      rdata_q     <= rdata_nxt;
      rvalid_q    <= rvalid_nxt;
    end
  end
endmodule
